byte_data_memory: RTL and testbench
===================================

// Module: byte_data_memory
// PURPOSE
//  Data memory for the single-cycle/pipelined CPU datapath, byte-addressed, with byte/half/word access.
//  Valid/ready request port, 1-cycle registered read response.
//  Misalignment detection; post-reset hardware clear sequencer (memory zeroed over DEPTH cycles).
//  Independent registered debug probe port. Sits between the ALU result/rt-data path and writeback mux.
// PARAMETERS
//  DEPTH           256  number of 32-bit words; power of two, >=4; IDX_W = $clog2(DEPTH)
//  ADDR_W          32   byte-address width; bits above [IDX_W+1:0] ignored (address wraps)
//  CLEAR_ON_RESET  1    1: zero memory after reset via clear sequencer; 0: contents retained over reset
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst           in   1       reset, synchronous, active-high
//  req_valid     in   1       request present
//  req_ready     out  1       block accepts request this cycle
//  req_we        in   1       1 = store, 0 = load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       load: 1 zero-extend, 0 sign-extend; ignored on store
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid     out  1       response for request accepted previous cycle
//  rsp_rdata     out  32      load result, extended; 0 for stores and errors
//  rsp_err       out  1       accepted request was misaligned or illegal size
//  busy          out  1       clear sequence in progress
//  probe_addr    in   IDX_W   debug word index
//  probe_data    out  32      memory[probe_addr], registered (1-cycle latency)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state<=CLEAR (CLEAR_ON_RESET=1) else IDLE; clr_ptr<=0; rsp_valid<=0,
//   rsp_rdata<=0, rsp_err<=0, probe_data<=0. In-flight response dropped. Reset mid-clear restarts at word 0.
//  FSM: CLEAR -> writes 0 to mem[clr_ptr], clr_ptr++ each cycle; at clr_ptr==DEPTH-1 -> IDLE (exactly DEPTH cycles).
//   IDLE -> stays until rst. busy = (state==CLEAR); req_ready = (state==IDLE). Both combinational from state.
//  Accept = req_valid & req_ready. No response back-pressure; one request per cycle, full throughput.
//  Word index = req_addr[IDX_W+1:2]; lane = req_addr[1:0].
//  Error: size==11, or half with lane[0]=1, or word with lane!=0 -> no write, rsp_err=1, rsp_rdata=0.
//  Store: write enables only addressed lanes (byte: lane; half: lane, lane+1; word: all 4); data
//   replicated onto lanes. rsp_valid=1 next cycle, rsp_rdata=0, rsp_err=0.
//  Load: rsp_valid/rsp_rdata next cycle; lane selected, shifted to [7:0]/[15:0], sign/zero-extended.
//  Back-to-back store then load same word: load returns new data (write commits at store's accept edge).
//  No accept -> rsp_valid=0 next cycle; rsp_rdata/rsp_err hold prior value.
//  probe_data <= mem[probe_addr] every cycle incl. CLEAR (reads pre-clear or cleared value; not guaranteed).
//  Storage: single-write-port array, write mux priority clear > request store.
// STRUCTURE
//  dmem_pkg: typedef enum logic[1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} dmem_size_t;
//   typedef enum logic {ST_CLEAR, ST_IDLE} dmem_state_t; function dmem_misaligned(size, lane).
//  Sub-module dmem_load_extract: combinational lane select + extension (word, lane, size, unsigned -> 32b).
//  Top holds FSM, clear pointer, byte-enable generation, array, response and probe registers.
// TESTING
//  1 rst 1 cycle, CLEAR_ON_RESET=1, DEPTH=256 -> busy=1, req_ready=0 for 256 cycles, then ready=1; probe any word = 0.
//  2 SW 0x8000_00F1 @0x10, LB @0x10 -> 0xFFFF_FFF1; LBU @0x13 -> 0x0000_0080; LH @0x12 -> 0xFFFF_8000.
//  3 SB 0xAB @0x21, then LW @0x20 next cycle (back-to-back) -> 0x0000_AB00, rsp_valid each cycle.
//  4 LW @0x22, SH @0x03, size=11 -> rsp_err=1, rdata=0; following LW of 0x00/0x20 shows memory unchanged.
//  5 SW 0x1234_5678 @0x400 (DEPTH=256 wraps to word 0) -> LW @0x0 returns 0x1234_5678.
//  6 rst asserted mid-clear and with load in flight -> rsp_valid=0 next cycle, clear restarts (256 more cycles);
//    CLEAR_ON_RESET=0 build: data written pre-reset readable immediately after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
// Access sizes, FSM states, lane enables and store-data replication.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_ILL
    } dmem_size_t;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } dmem_state_t;

    function automatic logic dmem_misaligned(
        input dmem_size_t size,
        input logic [1:0] lane
    );
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [LANES-1:0] dmem_byte_en(
        input dmem_size_t size,
        input logic [1:0] lane
    );
        logic [LANES-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is right-justified; copy it to every lane so the
    // byte enables alone pick where it lands.
    function automatic logic [WORD_W-1:0] dmem_replicate(
        input dmem_size_t size,
        input logic [WORD_W-1:0] wdata
    );
        logic [WORD_W-1:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/byte_data_memory_if.sv
// Request/response bundle between the datapath and the data memory.
// Master drives requests, slave returns the registered response.
interface byte_data_memory_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

endinterface

// File: rtl/dmem_load_extract.sv
// Load lane selection: shift the addressed byte/half down to bit 0
// and sign- or zero-extend it to a full word.
module dmem_load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  dmem_size_t  size,
    input  logic        unsigned_ext,
    output logic [31:0] data
);

    logic [15:0] sh;
    logic        sb;
    logic        sh_sign;

    assign sh      = 16'(word >> {lane, 3'b000});
    assign sb      = ~unsigned_ext & sh[7];
    assign sh_sign = ~unsigned_ext & sh[15];

    always_comb begin
        data = '0;
        unique case (size)
            SZ_BYTE: data = {{24{sb}}, sh[7:0]};
            SZ_HALF: data = {{16{sh_sign}}, sh};
            SZ_WORD: data = word;
            SZ_ILL:  data = '0;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory: valid/ready request port, 1-cycle
// registered response, post-reset clear sequencer, debug probe.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1,
    localparam int IDX_W         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    byte_data_memory_if.slave   bus,
    output logic                busy,
    input  logic [IDX_W-1:0]    probe_addr,
    output logic [31:0]         probe_data
);

    dmem_state_t      state_q;
    dmem_state_t      state_d;
    logic [IDX_W-1:0] clr_ptr;
    logic [31:0]      mem [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  widx;
    logic [1:0]        lane;
    dmem_size_t        size;
    logic              accept;
    logic              err;
    logic              clr_we;
    logic              st_we;
    logic [3:0]        be;
    logic [31:0]       wrep;
    logic [31:0]       rd_word;
    logic [31:0]       ld_data;
    logic              unused_addr;

    assign addr        = bus.req_addr;
    assign widx        = addr[IDX_W+1:2];
    assign lane        = addr[1:0];
    assign size        = dmem_size_t'(bus.req_size);
    assign unused_addr = &{1'b0, addr};

    assign busy          = (state_q == ST_CLEAR);
    assign bus.req_ready = (state_q == ST_IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign err           = dmem_misaligned(size, lane);

    assign clr_we = busy & ~rst;
    assign st_we  = accept & bus.req_we & ~err & ~rst;
    assign be     = dmem_byte_en(size, lane);
    assign wrep   = dmem_replicate(size, bus.req_wdata);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clr_ptr == IDX_W'(DEPTH - 1))
                    state_d = ST_IDLE;
            end
            ST_IDLE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (busy)
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Single write port: the clear sequencer wins over request stores.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[widx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[widx];

    dmem_load_extract u_extract (
        .word         (rd_word),
        .lane         (lane),
        .size         (size),
        .unsigned_ext (bus.req_unsigned),
        .data         (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= accept;
            if (accept) begin
                bus.rsp_err   <= err;
                bus.rsp_rdata <= (err | bus.req_we) ? '0 : ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            probe_data <= '0;
        else
            probe_data <= mem[probe_addr];
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed cases plus random
// traffic against a byte-array reference model.
module tb_byte_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [7:0]  probe_addr;
    logic [31:0] probe_data;

    logic        rst_nc;
    logic        busy_nc;
    logic [3:0]  probe_addr_nc;
    logic [31:0] probe_data_nc;

    int          ncmp = 0;
    int          nfail = 0;
    byte unsigned m [1024];
    logic [31:0] last_rd;
    logic        last_err;

    always #5 clk = ~clk;

    byte_data_memory_if #(.ADDR_W(32)) bus ();
    byte_data_memory_if #(.ADDR_W(32)) bus_nc ();

    byte_data_memory #(
        .DEPTH(256), .ADDR_W(32), .CLEAR_ON_RESET(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .probe_addr (probe_addr),
        .probe_data (probe_data)
    );

    byte_data_memory #(
        .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(0)
    ) dut_nc (
        .clk        (clk),
        .rst        (rst_nc),
        .bus        (bus_nc.slave),
        .busy       (busy_nc),
        .probe_addr (probe_addr_nc),
        .probe_data (probe_data_nc)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input int sz, input logic [31:0] a);
        if (sz == 3) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input int p);
        longint v = 0;
        for (int i = 0; i < 4; i++)
            v += longint'(m[4*p + i]) * (longint'(1) << (8*i));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input int sz, input bit uns,
                                             input logic [31:0] a);
        int     base = int'(a % 1024);
        int     n = 1 << sz;
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(m[base + i]) * (longint'(1) << (8*i));
        if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1)))
            v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic ref_store(input int sz, input logic [31:0] a,
                             input logic [31:0] wd);
        int base = int'(a % 1024);
        for (int i = 0; i < (1 << sz); i++)
            m[base + i] = 8'((wd >> (8*i)) & 32'hFF);
    endtask

    task automatic step(input logic v, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        logic [31:0] e_rd;
        logic [31:0] e_pr;
        logic        e_err;
        int          p;
        p = int'($urandom_range(0, 255));
        probe_addr = 8'(p);
        e_pr = ref_word(p);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        e_rd  = last_rd;
        e_err = last_err;
        if (v) begin
            e_err = ref_bad(int'(sz), a);
            e_rd  = '0;
            if (!e_err && !we) e_rd = ref_load(int'(sz), uns, a);
        end
        check({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (v && !e_err && we) ref_store(int'(sz), a, wd);
        bus.req_valid = 1'b0;
        check({tag, ".valid"}, {31'b0, bus.rsp_valid}, {31'b0, v});
        check({tag, ".err"}, {31'b0, bus.rsp_err}, {31'b0, e_err});
        check({tag, ".rdata"}, bus.rsp_rdata, e_rd);
        check({tag, ".probe"}, probe_data, e_pr);
        last_rd  = e_rd;
        last_err = e_err;
    endtask

    task automatic clear_wait(input string tag);
        int n = 0;
        bit rdy_seen = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (bus.req_ready !== 1'b0) rdy_seen = 1;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".cycles"}, 32'(n), 32'd256);
        check({tag, ".ready_low"}, {31'b0, rdy_seen}, 32'd0);
        check({tag, ".ready_after"}, {31'b0, bus.req_ready}, 32'd1);
        foreach (m[i]) m[i] = 8'h00;
    endtask

    task automatic nc_op(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp,
                         input string tag);
        bus_nc.req_valid    = 1'b1;
        bus_nc.req_we       = we;
        bus_nc.req_size     = 2'b10;
        bus_nc.req_unsigned = 1'b0;
        bus_nc.req_addr     = a;
        bus_nc.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus_nc.req_valid = 1'b0;
        check({tag, ".valid"}, {31'b0, bus_nc.rsp_valid}, 32'd1);
        check({tag, ".rdata"}, bus_nc.rsp_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        rst_nc = 1'b1;
        probe_addr = '0;
        probe_addr_nc = '0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus_nc.req_valid = 0; bus_nc.req_we = 0; bus_nc.req_size = 0;
        bus_nc.req_unsigned = 0; bus_nc.req_addr = 0; bus_nc.req_wdata = 0;
        last_rd = '0;
        last_err = 1'b0;

        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_nc = 1'b0;
        check("rst.busy", {31'b0, busy}, 32'd1);
        check("rst.ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst.valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst.rdata", bus.rsp_rdata, 32'd0);
        check("rst.err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst.probe", probe_data, 32'd0);
        check("nc.rst.busy", {31'b0, busy_nc}, 32'd0);
        check("nc.rst.ready", {31'b0, bus_nc.req_ready}, 32'd1);
        clear_wait("clr1");

        step(0, 0, 2'b00, 0, 32'h0, 32'h0, "idle0");
        step(1, 1, 2'b10, 0, 32'h10, 32'h8000_00F1, "sw10");
        step(1, 0, 2'b00, 0, 32'h10, 32'h0, "lb10");
        check("lb10.const", bus.rsp_rdata, 32'hFFFF_FFF1);
        step(1, 0, 2'b00, 1, 32'h13, 32'h0, "lbu13");
        check("lbu13.const", bus.rsp_rdata, 32'h0000_0080);
        step(1, 0, 2'b01, 0, 32'h12, 32'h0, "lh12");
        check("lh12.const", bus.rsp_rdata, 32'hFFFF_8000);

        step(1, 1, 2'b00, 0, 32'h21, 32'h0000_00AB, "sb21");
        step(1, 0, 2'b10, 0, 32'h20, 32'h0, "lw20");
        check("lw20.const", bus.rsp_rdata, 32'h0000_AB00);

        step(1, 0, 2'b10, 0, 32'h22, 32'h0, "lw22.mis");
        check("lw22.err", {31'b0, bus.rsp_err}, 32'd1);
        step(1, 1, 2'b01, 0, 32'h03, 32'h0000_FFFF, "sh03.mis");
        check("sh03.err", {31'b0, bus.rsp_err}, 32'd1);
        step(1, 1, 2'b11, 0, 32'h20, 32'hFFFF_FFFF, "sz11");
        check("sz11.err", {31'b0, bus.rsp_err}, 32'd1);
        step(0, 0, 2'b00, 0, 32'h0, 32'h0, "hold");
        step(1, 0, 2'b10, 0, 32'h00, 32'h0, "lw00");
        check("lw00.const", bus.rsp_rdata, 32'h0);
        step(1, 0, 2'b10, 0, 32'h20, 32'h0, "lw20b");
        check("lw20b.const", bus.rsp_rdata, 32'h0000_AB00);

        step(1, 1, 2'b10, 0, 32'h400, 32'h1234_5678, "sw400");
        step(1, 0, 2'b10, 0, 32'h0, 32'h0, "lw0wrap");
        check("lw0wrap.const", bus.rsp_rdata, 32'h1234_5678);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 2) != 0 && sz != 2'b11)
                a = a & ~((32'd1 << sz) - 32'd1);
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                 sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
        end

        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'b10;
        bus.req_addr = 32'h10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        check("rstfly.valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rstfly.rdata", bus.rsp_rdata, 32'd0);
        check("rstfly.err", {31'b0, bus.rsp_err}, 32'd0);
        check("rstfly.busy", {31'b0, busy}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_wait("clr2");
        last_rd = '0;
        last_err = 1'b0;
        step(1, 0, 2'b10, 0, 32'h10, 32'h0, "lw10.cleared");
        step(1, 0, 2'b10, 0, 32'h0, 32'h0, "lw0.cleared");

        nc_op(1'b1, 32'h08, 32'hA5A5_1234, 32'h0, "nc.sw08");
        nc_op(1'b1, 32'h3C, 32'hDEAD_BEEF, 32'h0, "nc.sw3c");
        rst_nc = 1'b1;
        @(posedge clk);
        #1;
        rst_nc = 1'b0;
        check("nc.rst2.busy", {31'b0, busy_nc}, 32'd0);
        check("nc.rst2.valid", {31'b0, bus_nc.rsp_valid}, 32'd0);
        probe_addr_nc = 4'd2;
        nc_op(1'b0, 32'h08, 32'h0, 32'hA5A5_1234, "nc.lw08");
        check("nc.probe2", probe_data_nc, 32'hA5A5_1234);
        nc_op(1'b0, 32'h3C, 32'h0, 32'hDEAD_BEEF, "nc.lw3c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
